// File: rtl/fc_layer_mac_if.sv
// fc_layer_mac_if
// ---------------
// Bundles every non-clock signal of the fully-connected layer engine:
//   input stream  : in_valid, in_ready, in_data (one activation per beat)
//   weight ROM    : w_addr out, w_q back one cycle later
//   bias ROM      : b_addr out, b_q back one cycle later
//   output stream : out_valid, out_ready, out_data, out_idx, out_last
//   status        : busy
// The slave modport is the engine's view; the master modport is the view of
// the environment around it (upstream producer, ROMs and downstream sink).
interface fc_layer_mac_if #(
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int OUT_W = 8,
    parameter int WA_W  = 13,
    parameter int BA_W  = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic [WA_W-1:0]         w_addr;
    logic signed [W_W-1:0]   w_q;
    logic [BA_W-1:0]         b_addr;
    logic signed [W_W-1:0]   b_q;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [BA_W-1:0]         out_idx;
    logic                    out_last;
    logic                    busy;

    modport slave (
        input  in_valid, in_data, w_q, b_q, out_ready,
        output in_ready, w_addr, b_addr, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_data, w_q, b_q, out_ready,
        input  in_ready, w_addr, b_addr, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/fc_layer_mac.sv
// fc_layer_mac
// ------------
// Fully-connected layer engine. Buffers one activation vector of IN_DIM
// signed elements, then for each of OUT_DIM neurons runs a signed MAC over
// weights read from an external synchronous ROM, adds a shifted bias,
// requantises with an arithmetic right shift, optionally applies ReLU and
// saturates to OUT_W bits. One result per output handshake.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : fc_layer_mac_if.slave (input stream, weight/bias ROM ports,
//           output stream, busy)
module fc_layer_mac #(
    parameter int IN_DIM      = 256,
    parameter int OUT_DIM     = 32,
    parameter int IN_W        = 8,
    parameter int W_W         = 8,
    parameter int ACC_W       = 32,
    parameter int OUT_SHIFT   = 7,
    parameter int BIAS_LSHIFT = 7,
    parameter int RELU        = 1,
    parameter int OUT_W       = 8,
    parameter int WA_W        = $clog2(IN_DIM * OUT_DIM),
    parameter int BA_W        = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fc_layer_mac_if.slave bus
);
    localparam int CNT_W = $clog2(IN_DIM);
    localparam logic [CNT_W-1:0] LAST_I = CNT_W'(IN_DIM - 1);
    localparam logic [BA_W-1:0]  LAST_O = BA_W'(OUT_DIM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {ST_LOAD, ST_MAC, ST_DRAIN, ST_POST, ST_OUT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        i_cnt;
    logic [BA_W-1:0]         o_cnt;
    logic [WA_W-1:0]         w_addr_q;
    logic signed [IN_W-1:0]  act_buf [IN_DIM];
    logic signed [IN_W-1:0]  act_q;
    logic                    mac_pend;
    logic                    mac_first;
    logic signed [ACC_W-1:0] acc;
    logic signed [OUT_W-1:0] out_data_q;
    logic [BA_W-1:0]         out_idx_q;
    logic                    out_last_q;

    logic                    in_ready_c;
    logic                    out_valid_c;
    logic                    busy_c;
    logic                    in_fire;
    logic                    out_fire;
    logic signed [W_W-1:0]   w_s;
    logic signed [W_W-1:0]   b_s;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] clamped;

    assign in_fire  = bus.in_valid & in_ready_c;
    assign out_fire = bus.out_ready & out_valid_c;

    // Both operands are sign-extended to the accumulator width before the
    // multiply so the product is exact for any legal parameter set.
    assign w_s      = bus.w_q;
    assign b_s      = bus.b_q;
    assign prod     = ACC_W'(act_q) * ACC_W'(w_s);
    assign bias_ext = ACC_W'(b_s);
    assign biased   = acc + (bias_ext <<< BIAS_LSHIFT);
    assign shifted  = biased >>> OUT_SHIFT;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN exists because the ROM data and the registered
    // activation for the last weight only meet one cycle after its address.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:  if (in_fire && i_cnt == LAST_I) state_next = ST_MAC;
            ST_MAC:   if (i_cnt == LAST_I) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_POST;
            ST_POST:  state_next = ST_OUT;
            ST_OUT:   if (out_fire) state_next = (o_cnt == LAST_O) ? ST_LOAD : ST_MAC;
            default:  state_next = ST_LOAD;
        endcase
    end

    // Output decode: handshake strobes and busy follow directly from state.
    always_comb begin
        in_ready_c  = (state == ST_LOAD);
        out_valid_c = (state == ST_OUT);
        busy_c      = (state != ST_LOAD);
    end

    // Activation storage has no reset: it is always fully rewritten before
    // the MAC phase reads it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            act_buf[i_cnt] <= bus.in_data;
        end
    end

    // Counters and weight address. w_addr is a running pointer: it advances
    // on every MAC cycle but the last of a neuron, and the step into the
    // next neuron happens on the output transfer, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt     <= '0;
            o_cnt     <= '0;
            w_addr_q  <= '0;
            act_q     <= '0;
            mac_pend  <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_pend <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (i_cnt == LAST_I) begin
                            i_cnt    <= '0;
                            o_cnt    <= '0;
                            w_addr_q <= '0;
                        end else begin
                            i_cnt <= i_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_MAC: begin
                    act_q     <= act_buf[i_cnt];
                    mac_pend  <= 1'b1;
                    mac_first <= (i_cnt == '0);
                    if (i_cnt == LAST_I) begin
                        i_cnt <= '0;
                    end else begin
                        i_cnt    <= i_cnt + CNT_W'(1);
                        w_addr_q <= w_addr_q + WA_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_fire) begin
                        if (o_cnt == LAST_O) begin
                            o_cnt    <= '0;
                            w_addr_q <= '0;
                        end else begin
                            o_cnt    <= o_cnt + BA_W'(1);
                            w_addr_q <= w_addr_q + WA_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator: the first product of a neuron overwrites instead of adding,
    // which saves a separate clear cycle between neurons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (mac_pend) begin
            acc <= mac_first ? prod : acc + prod;
        end
    end

    // ReLU then saturation into the signed output range.
    always_comb begin
        clamped = shifted;
        if (RELU != 0 && shifted[ACC_W-1]) begin
            clamped = '0;
        end else if (shifted > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN;
        end
    end

    // Result registers are loaded only in POST, so they stay stable for the
    // whole OUT phase regardless of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else if (state == ST_POST) begin
            out_data_q <= clamped[OUT_W-1:0];
            out_idx_q  <= o_cnt;
            out_last_q <= (o_cnt == LAST_O);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = o_cnt;
endmodule

// File: tb/tb_fc_layer_mac.sv
// tb_fc_layer_mac
// ---------------
// Self-checking bench for fc_layer_mac. Two small instances (IN_DIM=4,
// OUT_DIM=2) with different requantisation settings share clk/rst_n:
//   dut_a : OUT_SHIFT=0, BIAS_LSHIFT=0, RELU=1
//   dut_b : OUT_SHIFT=1, BIAS_LSHIFT=1, RELU=0
// Each has a behavioural weight/bias ROM with one cycle of latency.
// Expected neuron results are computed by a reference model when a vector
// is driven, queued, and compared when the output handshake completes.
module tb_fc_layer_mac;
    localparam int A_OSH = 0;
    localparam int A_BSH = 0;
    localparam int A_RELU = 1;
    localparam int B_OSH = 1;
    localparam int B_BSH = 1;
    localparam int B_RELU = 0;

    typedef struct {
        int data;
        int idx;
        int last;
    } exp_t;

    logic clk;
    logic rst_n;

    int   total;
    int   bad;
    int   act_a [4];
    int   act_b [4];
    int   wrom_a [8];
    int   wrom_b [8];
    int   brom_a [2];
    int   brom_b [2];
    exp_t q_a [$];
    exp_t q_b [$];
    exp_t mon_a;
    exp_t mon_b;

    fc_layer_mac_if #(.IN_W(8), .W_W(8), .OUT_W(8), .WA_W(3), .BA_W(1)) bus_a ();
    fc_layer_mac_if #(.IN_W(8), .W_W(8), .OUT_W(8), .WA_W(3), .BA_W(1)) bus_b ();

    fc_layer_mac #(
        .IN_DIM(4), .OUT_DIM(2), .IN_W(8), .W_W(8), .ACC_W(32),
        .OUT_SHIFT(A_OSH), .BIAS_LSHIFT(A_BSH), .RELU(A_RELU),
        .OUT_W(8), .WA_W(3), .BA_W(1)
    ) dut_a (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_a)
    );

    fc_layer_mac #(
        .IN_DIM(4), .OUT_DIM(2), .IN_W(8), .W_W(8), .ACC_W(32),
        .OUT_SHIFT(B_OSH), .BIAS_LSHIFT(B_BSH), .RELU(B_RELU),
        .OUT_W(8), .WA_W(3), .BA_W(1)
    ) dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_b)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: data appears one cycle after the address.
    always @(posedge clk) begin
        bus_a.w_q <= 8'(wrom_a[bus_a.w_addr]);
        bus_a.b_q <= 8'(brom_a[bus_a.b_addr]);
        bus_b.w_q <= 8'(wrom_b[bus_b.w_addr]);
        bus_b.b_q <= 8'(brom_b[bus_b.b_addr]);
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Floor division for a positive divisor.
    function automatic int floorDiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    // Reference model of one neuron for the selected instance.
    function automatic int refNeuron(input bit sel, input int o);
        int acc;
        int t;
        int r;
        int bsh;
        int osh;
        int relu;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            acc += sel ? act_b[k] * wrom_b[o*4 + k] : act_a[k] * wrom_a[o*4 + k];
        end
        bsh  = sel ? B_BSH : A_BSH;
        osh  = sel ? B_OSH : A_OSH;
        relu = sel ? B_RELU : A_RELU;
        t = acc + (sel ? brom_b[o] : brom_a[o]) * (1 << bsh);
        r = floorDiv(t, 1 << osh);
        if (relu != 0 && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Loads both neurons' weights and biases into the selected ROM.
    task automatic setRom(input bit sel, input int w0, input int w1, input int w2, input int w3,
                          input int w4, input int w5, input int w6, input int w7,
                          input int b0, input int b1);
        int w [8];
        w = '{w0, w1, w2, w3, w4, w5, w6, w7};
        for (int k = 0; k < 8; k++) begin
            if (sel) wrom_b[k] = w[k];
            else     wrom_a[k] = w[k];
        end
        if (sel) begin
            brom_b[0] = b0;
            brom_b[1] = b1;
        end else begin
            brom_a[0] = b0;
            brom_a[1] = b1;
        end
    endtask

    // Drives one vector, optionally with idle gaps carrying junk data, and
    // optionally leaving in_valid high with junk after the last beat.
    // Returns one time unit after the edge that accepted the last beat.
    task automatic applyStimulus(input bit sel, input int a0, input int a1, input int a2,
                                 input int a3, input bit gaps, input bit hold);
        int   v [4];
        int   k;
        int   guard;
        logic vld;
        logic rdy;
        exp_t e;
        v = '{a0, a1, a2, a3};
        for (int j = 0; j < 4; j++) begin
            if (sel) act_b[j] = v[j];
            else     act_a[j] = v[j];
        end
        for (int o = 0; o < 2; o++) begin
            e.data = refNeuron(sel, o);
            e.idx  = o;
            e.last = (o == 1) ? 1 : 0;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        k = 0;
        guard = 0;
        @(posedge clk);
        #1;
        while (k < 4 && guard < 100) begin
            vld = !(gaps && (guard % 2 == 1));
            if (sel) begin
                bus_b.in_valid = vld;
                bus_b.in_data  = vld ? 8'(v[k]) : 8'd100;
                rdy = bus_b.in_ready;
            end else begin
                bus_a.in_valid = vld;
                bus_a.in_data  = vld ? 8'(v[k]) : 8'd100;
                rdy = bus_a.in_ready;
            end
            @(posedge clk);
            if (vld && rdy) k++;
            guard++;
            #1;
        end
        if (hold) begin
            if (sel) bus_b.in_data = -8'sd77;
            else     bus_a.in_data = -8'sd77;
        end else begin
            if (sel) bus_b.in_valid = 1'b0;
            else     bus_a.in_valid = 1'b0;
        end
        checkOutput("load_beats", k, 4);
    endtask

    // Waits, with a cycle budget, until every queued result has been seen.
    task automatic waitDrain(input bit sel, input string tag);
        int c;
        c = 0;
        while (c < 200 && ((sel ? q_b.size() : q_a.size()) != 0 ||
                           (sel ? bus_b.busy : bus_a.busy))) begin
            @(posedge clk);
            c++;
        end
        checkOutput(tag, sel ? q_b.size() : q_a.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Cycles from the MAC entry cycle until out_valid is seen high.
    task automatic checkLatency(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_a.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, n, 6);
    endtask

    // Scoreboard monitor for dut_a: compares on each completed handshake.
    always @(negedge clk) begin
        if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) begin
                checkOutput("a_unexpected", int'(bus_a.out_idx), -1);
            end else begin
                mon_a = q_a.pop_front();
                checkOutput("a_data", int'(bus_a.out_data), mon_a.data);
                checkOutput("a_idx", int'(bus_a.out_idx), mon_a.idx);
                checkOutput("a_last", int'(bus_a.out_last), mon_a.last);
            end
        end
    end

    // Scoreboard monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) begin
                checkOutput("b_unexpected", int'(bus_b.out_idx), -1);
            end else begin
                mon_b = q_b.pop_front();
                checkOutput("b_data", int'(bus_b.out_data), mon_b.data);
                checkOutput("b_idx", int'(bus_b.out_idx), mon_b.idx);
                checkOutput("b_last", int'(bus_b.out_last), mon_b.last);
            end
        end
    end

    // Main sequence.
    initial begin
        int c;
        int exp0;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = '0;
        bus_b.out_ready = 1'b1;
        setRom(0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 5);
        setRom(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_in_ready", int'(bus_a.in_ready), 1);
        checkOutput("rst_busy", int'(bus_a.busy), 0);
        checkOutput("rst_out_valid", int'(bus_a.out_valid), 0);
        checkOutput("rst_out_data", int'(bus_a.out_data), 0);
        checkOutput("rst_out_idx", int'(bus_a.out_idx), 0);
        checkOutput("rst_out_last", int'(bus_a.out_last), 0);
        checkOutput("rst_w_addr", int'(bus_a.w_addr), 0);
        checkOutput("rst_b_addr", int'(bus_a.b_addr), 0);

        $display("[TB] basic vector with latency");
        applyStimulus(0, 1, 2, 3, 4, 0, 0);
        checkLatency("latency");
        waitDrain(0, "drain_basic");

        $display("[TB] saturation and relu");
        setRom(0, 127, 127, 127, 127, 127, 127, 127, 127, 0, 0);
        applyStimulus(0, 127, 127, 127, 127, 0, 0);
        waitDrain(0, "drain_sat_pos");
        applyStimulus(0, -128, -128, -128, -128, 0, 0);
        waitDrain(0, "drain_relu");

        $display("[TB] backpressure");
        setRom(0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 5);
        bus_a.out_ready = 1'b0;
        applyStimulus(0, 1, 2, 3, 4, 0, 0);
        exp0 = refNeuron(0, 0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus_a.out_valid && c < 50);
        for (int s = 0; s < 5; s++) begin
            checkOutput("bp_valid", int'(bus_a.out_valid), 1);
            checkOutput("bp_data", int'(bus_a.out_data), exp0);
            checkOutput("bp_idx", int'(bus_a.out_idx), 0);
            checkOutput("bp_w_addr_blk", int'(bus_a.w_addr) / 4, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus_a.out_ready = 1'b1;
        waitDrain(0, "drain_bp");

        $display("[TB] gapped input");
        applyStimulus(0, 5, 6, 7, 8, 1, 0);
        waitDrain(0, "drain_gaps");

        $display("[TB] in_valid held during compute");
        applyStimulus(0, 2, 2, 2, 2, 0, 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", int'(bus_a.in_ready), 0);
            checkOutput("hold_busy", int'(bus_a.busy), 1);
        end
        @(posedge clk);
        #1 bus_a.in_valid = 1'b0;
        waitDrain(0, "drain_hold");
        applyStimulus(0, 3, 1, 4, 1, 0, 0);
        waitDrain(0, "drain_second");

        $display("[TB] reset during neuron 1");
        applyStimulus(0, 1, 2, 3, 4, 0, 0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus_a.out_valid && c < 50);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_busy", int'(bus_a.busy), 1);
        rst_n = 1'b0;
        q_a.delete();
        #1;
        checkOutput("mid_rst_out_valid", int'(bus_a.out_valid), 0);
        checkOutput("mid_rst_out_data", int'(bus_a.out_data), 0);
        checkOutput("mid_rst_out_idx", int'(bus_a.out_idx), 0);
        checkOutput("mid_rst_out_last", int'(bus_a.out_last), 0);
        checkOutput("mid_rst_busy", int'(bus_a.busy), 0);
        checkOutput("mid_rst_w_addr", int'(bus_a.w_addr), 0);
        checkOutput("mid_rst_b_addr", int'(bus_a.b_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, 1, 2, 3, 4, 0, 0);
        checkLatency("latency_after_rst");
        waitDrain(0, "drain_after_rst");

        $display("[TB] requantisation on second instance");
        applyStimulus(1, -3, 0, 0, 0, 0, 0);
        waitDrain(1, "drain_floor");
        setRom(1, 127, 127, 127, 127, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, -128, -128, -128, -128, 0, 0);
        waitDrain(1, "drain_sat_neg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so a stuck design still produces a summary.
    initial begin
        #200000;
        checkOutput("global_timeout", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] global time limit reached");
    end
endmodule
